// File: rtl/msrv_img_pipe.sv
// Pipelined immediate generator: decodes the immediate and registers it with its tag.
// Define MSRV_IMG_SKID_EN for a 2-entry skid buffer with a registered instr_ready_out.
module msrv_img_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 8
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_n_in,
  input  logic             instr_valid_in,
  output logic             instr_ready_out,
  input  logic [31:0]      instr_in,
  input  logic [2:0]       imm_type_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             imm_valid_out,
  input  logic             imm_ready_in,
  output logic [XLEN-1:0]  imm_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             imm_err_out,
  input  logic             err_clr_in,
  output logic [CNT_W-1:0] err_count_out
);

  logic [31:0]      imm32;
  logic [XLEN-1:0]  imm_calc;
  logic             err_calc;
  logic             sgn;
  logic             in_xfer;
  logic             out_xfer;

  logic             valid_q;
  logic [XLEN-1:0]  imm_q;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  // Opcode bits never contribute to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr_in[6:0];

  assign sgn = instr_in[31];

  always_comb begin
    imm32    = '0;
    err_calc = 1'b0;
    unique case (imm_type_in)
      3'b000, 3'b001: imm32 = {{20{sgn}}, instr_in[31:20]};
      3'b010:         imm32 = {{20{sgn}}, instr_in[31:25], instr_in[11:7]};
      3'b011:         imm32 = {{19{sgn}}, sgn, instr_in[7], instr_in[30:25],
                               instr_in[11:8], 1'b0};
      3'b100:         imm32 = {instr_in[31:12], 12'h000};
      3'b101:         imm32 = {{11{sgn}}, sgn, instr_in[19:12], instr_in[20],
                               instr_in[30:21], 1'b0};
      3'b110:         imm32 = {27'd0, instr_in[19:15]};
      default:        err_calc = 1'b1;
    endcase
    // All formats fit in 32 bits; widen by replicating bit 31 (CSR has bit 31 clear).
    imm_calc        = {XLEN{imm32[31]}};
    imm_calc[31:0]  = imm32;
  end

  assign in_xfer  = instr_valid_in && instr_ready_out;
  assign out_xfer = valid_q && imm_ready_in;

`ifdef MSRV_IMG_SKID_EN
  logic             skid_valid_q;
  logic [XLEN-1:0]  skid_imm_q;
  logic [TAG_W-1:0] skid_tag_q;
  logic             skid_err_q;

  assign instr_ready_out = !skid_valid_q;

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      valid_q      <= 1'b0;
      imm_q        <= '0;
      tag_q        <= '0;
      err_q        <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_err_q   <= 1'b0;
    end else if (skid_valid_q) begin
      if (out_xfer) begin
        imm_q        <= skid_imm_q;
        tag_q        <= skid_tag_q;
        err_q        <= skid_err_q;
        skid_valid_q <= 1'b0;
      end
    end else if (in_xfer) begin
      if (!valid_q || out_xfer) begin
        valid_q <= 1'b1;
        imm_q   <= imm_calc;
        tag_q   <= tag_in;
        err_q   <= err_calc;
      end else begin
        skid_valid_q <= 1'b1;
        skid_imm_q   <= imm_calc;
        skid_tag_q   <= tag_in;
        skid_err_q   <= err_calc;
      end
    end else if (out_xfer) begin
      valid_q <= 1'b0;
    end
  end
`else
  assign instr_ready_out = !valid_q || imm_ready_in;

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      valid_q <= 1'b0;
      imm_q   <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else if (in_xfer) begin
      valid_q <= 1'b1;
      imm_q   <= imm_calc;
      tag_q   <= tag_in;
      err_q   <= err_calc;
    end else if (out_xfer) begin
      valid_q <= 1'b0;
    end
  end
`endif

  // A clear coinciding with a reserved accept leaves the count at 1.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      cnt_q <= '0;
    end else if (in_xfer && err_calc) begin
      if (err_clr_in)  cnt_q <= CNT_W'(1);
      else if (!(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end else if (err_clr_in) begin
      cnt_q <= '0;
    end
  end

  assign imm_valid_out = valid_q;
  assign imm_out       = imm_q;
  assign tag_out       = tag_q;
  assign imm_err_out   = err_q;
  assign err_count_out = cnt_q;

endmodule
